// File: rtl/bus_hub.sv
// bus_hub: priority-encoded datapath bus multiplexer with a registered keeper,
// multi-driver conflict detection, a saturating conflict counter and a
// registered winning-source index.
// Optional build macro: BUS_HUB_STRICT_EN -- a conflict cycle forces the bus
// to zero and records the reserved all-ones index instead of the winner.
module bus_hub #(
    parameter int WIDTH = 32,
    parameter int N_SRC = 24,
    parameter int IDX_W = 5,
    parameter int CNT_W = 8
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [N_SRC-1:0]       src_en,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic                   hold,
    output logic [WIDTH-1:0]       bus_comb,
    output logic [WIDTH-1:0]       bus_q,
    output logic                   bus_valid,
    output logic [IDX_W-1:0]       src_idx,
    output logic                   conflict,
    output logic [CNT_W-1:0]       conflict_cnt
);

`ifdef BUS_HUB_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [WIDTH-1:0] win_data;
    logic             multi_en;
    logic             strict_err;
    logic             cnt_full;

    // Priority encoder: the lowest-index asserted enable wins the bus.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (src_en[i] && !win_found) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_data  = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Two or more enables: clearing the lowest set bit leaves something set.
    always_comb begin
        multi_en   = |(src_en & (src_en - N_SRC'(1)));
        strict_err = STRICT && multi_en;
        cnt_full   = &conflict_cnt;
    end

    // Combinational bus: winner, zero on a strict conflict, else the keeper.
    always_comb begin
        if (strict_err) begin
            bus_comb = '0;
        end else if (win_found) begin
            bus_comb = win_data;
        end else begin
            bus_comb = bus_q;
        end
    end

    // Keeper and status registers; clear beats hold, hold freezes everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            bus_q        <= '0;
            bus_valid    <= 1'b0;
            src_idx      <= '0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else if (!hold) begin
            bus_valid <= win_found;
            conflict  <= multi_en;
            if (multi_en && !cnt_full) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
            if (win_found) begin
                bus_q   <= bus_comb;
                src_idx <= strict_err ? '1 : win_idx;
            end
        end
    end

endmodule

// File: tb/tb_bus_hub.sv
// Scoreboard bench for bus_hub: a directed table of input rows with
// hand-computed expectations; a negedge monitor pops and compares.
module tb_bus_hub;

`ifdef BUS_HUB_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic           clock;
    logic           clear;
    logic [23:0]    src_en;
    logic [24*32-1:0] src_data;
    logic           hold;
    logic [31:0]    bus_comb;
    logic [31:0]    bus_q;
    logic           bus_valid;
    logic [4:0]     src_idx;
    logic           conflict;
    logic [3:0]     conflict_cnt;

    bus_hub #(
        .WIDTH(32),
        .N_SRC(24),
        .IDX_W(5),
        .CNT_W(4)
    ) dut (
        .clock(clock),
        .clear(clear),
        .src_en(src_en),
        .src_data(src_data),
        .hold(hold),
        .bus_comb(bus_comb),
        .bus_q(bus_q),
        .bus_valid(bus_valid),
        .src_idx(src_idx),
        .conflict(conflict),
        .conflict_cnt(conflict_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One stimulus row: inputs, bus_comb for those inputs, registers after its edge.
    typedef struct {
        logic [23:0] en;
        logic        hold;
        logic        clear;
        logic        chk_comb;
        logic [31:0] comb;
        logic [31:0] q;
        logic        valid;
        logic [4:0]  idx;
        logic        conf;
        logic [3:0]  cnt;
    } row_t;

    typedef struct {
        int          row;
        logic        chk_comb;
        logic        chk_reg;
        logic [31:0] comb;
        logic [31:0] q;
        logic        valid;
        logic [4:0]  idx;
        logic        conf;
        logic [3:0]  cnt;
    } exp_t;

    row_t rows[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic [23:0] en, input logic h, input logic c,
                       input logic cc, input logic [31:0] comb,
                       input logic [31:0] q, input logic v, input logic [4:0] idx,
                       input logic conf, input logic [3:0] cnt);
        row_t r;
        r.en = en; r.hold = h; r.clear = c; r.chk_comb = cc; r.comb = comb;
        r.q = q; r.valid = v; r.idx = idx; r.conf = conf; r.cnt = cnt;
        rows.push_back(r);
    endtask

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, req);
        end
    endtask

    // Monitor: every cycle with a pending expectation, compare outputs.
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_comb) chk("bus_comb", e.row, bus_comb, e.comb);
            if (e.chk_reg) begin
                chk("bus_q",        e.row, bus_q,               e.q);
                chk("bus_valid",    e.row, 32'(bus_valid),      32'(e.valid));
                chk("src_idx",      e.row, 32'(src_idx),        32'(e.idx));
                chk("conflict",     e.row, 32'(conflict),       32'(e.conf));
                chk("conflict_cnt", e.row, 32'(conflict_cnt),   32'(e.cnt));
            end
        end
    end

    initial begin
        logic [31:0] v11, v_db, v_a1;
        logic [4:0]  i5, i0, i1;
        exp_t e;
        row_t prev;

        for (int i = 0; i < 24; i++) src_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        src_data[3*32  +: 32] = 32'h0000_00B6;
        src_data[5*32  +: 32] = 32'h1111_1111;
        src_data[20*32 +: 32] = 32'h2222_2222;
        src_data[0*32  +: 32] = 32'hDEAD_BEEF;
        src_data[23*32 +: 32] = 32'hFFFF_0001;
        src_en = '0; hold = 1'b0; clear = 1'b0;

        // Conflict-cycle bus values and indices depend on the strict build.
        v11  = STRICT ? 32'h0 : 32'h1111_1111;
        v_db = STRICT ? 32'h0 : 32'hDEAD_BEEF;
        v_a1 = STRICT ? 32'h0 : 32'hA000_0001;
        i5   = STRICT ? 5'd31 : 5'd5;
        i0   = STRICT ? 5'd31 : 5'd0;
        i1   = STRICT ? 5'd31 : 5'd1;

        //   en            hold clr  cc  comb           q              v  idx    cf cnt
        add(24'h0,         0,   1,   0,  32'h0,         32'h0,         0, 5'd0,  0, 4'd0);
        add(24'h0,         0,   0,   1,  32'h0,         32'h0,         0, 5'd0,  0, 4'd0);
        add(24'h000008,    0,   0,   1,  32'hB6,        32'hB6,        1, 5'd3,  0, 4'd0);
        add(24'h0,         0,   0,   1,  32'hB6,        32'hB6,        0, 5'd3,  0, 4'd0);
        add(24'h100020,    0,   0,   1,  v11,           v11,           1, i5,    1, 4'd1);
        add(24'h0,         0,   0,   1,  v11,           v11,           0, i5,    0, 4'd1);
        add(24'hFFFFFF,    0,   0,   1,  v_db,          v_db,          1, i0,    1, 4'd2);
        add(24'h800000,    0,   0,   1,  32'hFFFF_0001, 32'hFFFF_0001, 1, 5'd23, 0, 4'd2);
        for (int k = 1; k <= 20; k++)
            add(24'h000006, 0,  0,   1,  v_a1,          v_a1,          1, i1,    1,
                (k + 2 > 15) ? 4'd15 : 4'(k + 2));
        add(24'h0,         0,   0,   1,  v_a1,          v_a1,          0, i1,    0, 4'd15);
        add(24'h000001,    1,   0,   1,  32'hDEAD_BEEF, v_a1,          0, i1,    0, 4'd15);
        add(24'h000001,    1,   1,   1,  32'hDEAD_BEEF, 32'h0,         0, 5'd0,  0, 4'd0);
        add(24'h0,         0,   0,   1,  32'h0,         32'h0,         0, 5'd0,  0, 4'd0);

        // Row r's registers are visible during row r+1, so each expectation
        // pairs this row's bus_comb with the previous row's register values.
        foreach (rows[r]) begin
            @(posedge clock);
            #1;
            src_en = rows[r].en;
            hold   = rows[r].hold;
            clear  = rows[r].clear;
            e.row      = r;
            e.chk_comb = rows[r].chk_comb;
            e.comb     = rows[r].comb;
            e.chk_reg  = (r > 0);
            prev = (r > 0) ? rows[r-1] : rows[r];
            e.q = prev.q; e.valid = prev.valid; e.idx = prev.idx;
            e.conf = prev.conf; e.cnt = prev.cnt;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        src_en = '0; hold = 1'b0; clear = 1'b0;
        prev = rows[rows.size()-1];
        e.row = rows.size(); e.chk_comb = 1'b0; e.comb = '0; e.chk_reg = 1'b1;
        e.q = prev.q; e.valid = prev.valid; e.idx = prev.idx;
        e.conf = prev.conf; e.cnt = prev.cnt;
        sb.push_back(e);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_hub.md
Name: bus_hub

Overview:
- Parametrised successor to the CPU datapath bus multiplexer.
- Selects one of N_SRC WIDTH-bit sources onto the shared datapath bus using a priority encoder.
- Adds a registered bus-keeper copy of the bus, multi-driver conflict detection, a saturating conflict counter, and a registered driver index for debug and control-unit checking.
- Sits between the register file, special registers (HI, LO, Z, PC, MDR, InPort, C) and all bus consumers.

Parameters:
- WIDTH, 32, bus data width in bits.
- N_SRC, 24, number of bus sources; index 0 has the highest priority.
- IDX_W, 5, width of the source index output; must satisfy 2^IDX_W > N_SRC.
- CNT_W, 8, width of the conflict counter.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  synchronous active-high reset.
- src_en  in  N_SRC  per-source output enables; bit i corresponds to source i.
- src_data  in  N_SRC*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH].
- hold  in  1  freezes the keeper register and the status registers.
- bus_comb  out  WIDTH  combinational bus value, for same-cycle register loads.
- bus_q  out  WIDTH  registered bus keeper.
- bus_valid  out  1  registered; 1 if any source drove the bus in the previous cycle.
- src_idx  out  IDX_W  registered index of the winning source.
- conflict  out  1  registered; 1 if two or more enables were asserted in the previous cycle.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles.

Behaviour:
- Combinational path:
  - bus_comb = src_data of the lowest-index asserted src_en bit.
  - With no enable asserted, bus_comb = bus_q (keeper value). The combinational path never produces X and never infers a latch.
- Registered path: on each rising edge of clock, evaluated in this priority order:
  - clear=1: bus_q=0, bus_valid=0, src_idx=0, conflict=0, conflict_cnt=0. clear overrides hold.
  - Otherwise, hold=1: all registers keep their values; bus_comb still follows the inputs.
  - Otherwise, any enable asserted: bus_q<=bus_comb, bus_valid<=1, src_idx<=winning index.
  - Otherwise, no enable asserted: bus_q keeps its value, bus_valid<=0, src_idx keeps its value.
- Conflict detection:
  - When not in hold, conflict <= (popcount(src_en) >= 2).
  - conflict_cnt increments by 1 on each such cycle and saturates at 2^CNT_W-1; it never wraps.
- Latency: bus_comb has 0 cycles of latency; bus_q, src_idx, bus_valid and conflict have 1 cycle.
- Boundaries:
  - All N_SRC enables asserted: source 0 wins and conflict is set.
  - Only the top source (N_SRC-1) enabled: its data is selected with no conflict.
  - clear asserted mid-transfer: the next edge zeroes all registers, and bus_comb then shows 0 if no source is enabled.
  - Enable bits above N_SRC do not exist; src_idx never reports an index of N_SRC or above.

Optional Feature:
- BUS_HUB_STRICT_EN defined:
  - In any conflict cycle, bus_comb = 0 instead of the priority winner.
  - On that edge, bus_q loads 0 and src_idx loads all-ones (reserved error index).
  - conflict and conflict_cnt behave as in the base block.
- BUS_HUB_STRICT_EN undefined: the priority winner drives the bus during a conflict, as described in Behaviour.

Test Plan:
- Reset and keeper: assert clear for 1 cycle, then no enables -> bus_q=0, bus_comb=0, bus_valid=0, conflict_cnt=0.
- Single drive: src_en bit 3 set with source 3 = 0x000000B6 -> bus_comb=0xB6 in the same cycle; next edge bus_q=0xB6, src_idx=3, bus_valid=1. Then drop all enables -> bus_comb=0xB6 and bus_q=0xB6 held, bus_valid=0.
- Priority conflict: bits 5 and 20 set, source 5 = 0x11111111, source 20 = 0x22222222 -> bus_comb=0x11111111; next edge src_idx=5, conflict=1, conflict_cnt=1. With BUS_HUB_STRICT_EN defined -> bus_comb=0, bus_q=0, src_idx=all-ones.
- Saturation: CNT_W=4, 20 consecutive conflict cycles -> conflict_cnt=15 and stays at 15.
- Hold versus clear: hold=1 while bit 0 drives 0xDEADBEEF -> bus_comb=0xDEADBEEF, bus_q unchanged. Then assert clear with hold=1 -> all registers zero on that edge.
- Top index: only bit N_SRC-1 (23) set with source 23 = 0xFFFF0001 -> bus_q=0xFFFF0001, src_idx=23, conflict=0.
